fc_dataflow_sequencer: RTL

Start-token scheduler for the three-stage FC apply dataflow region: load_data, compute_pro and output_result. It replaces the HLS start FIFOs with counters and issues ap_start to each stage with bounded look-ahead. It counts iterations and runs a no-progress watchdog, so that a hung region is flagged in hardware as well as in simulation. It sits between the FC layer control (fc_SERIAL_FC) and the apply region.

---
 rtl/fc_seq_pkg.sv | 16 +
 rtl/fc_seq_tok_cnt.sv | 35 +++
 rtl/fc_dataflow_sequencer.sv | 136 +++++++++++++
 3 files changed

// File: rtl/fc_seq_pkg.sv
// Shared constants for the FC apply-region start-token sequencer:
// FSM state codes, stage bit positions and the default watchdog limit.
package fc_seq_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;

    // Bit positions of each stage inside stall_stage
    localparam int LD = 0;
    localparam int CP = 1;
    localparam int OR = 2;

    localparam int DEFAULT_STALL_CYC = 4096;

endpackage

// File: rtl/fc_seq_tok_cnt.sv
// Up/down start-token counter bounded to 0..DEPTH; stands in for one HLS start FIFO.
// Simultaneous inc and dec cancel; inc at full and dec at empty are dropped.
module fc_seq_tok_cnt
    import fc_seq_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    input  logic dec,
    output logic full,
    output logic nonempty
);

    logic [CW-1:0] count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !dec && !full) begin
            count <= count + 1'b1;
        end else if (dec && !inc && nonempty) begin
            count <= count - 1'b1;
        end
    end

    assign full     = (count == CW'(DEPTH));
    assign nonempty = (count != '0);

endmodule

// File: rtl/fc_dataflow_sequencer.sv
// Start-token scheduler for the load_data -> compute_pro -> output_result region,
// with iteration counting and a sticky no-progress watchdog.
module fc_dataflow_sequencer
    import fc_seq_pkg::*;
#(
    parameter int ITER_W    = 16,
    parameter int DEPTH     = 2,
    parameter int STALL_CYC = DEFAULT_STALL_CYC,
    parameter int WD_W      = 13
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cfg_start,
    input  logic [ITER_W-1:0] cfg_num_iter,
    output logic              busy,
    output logic              done,
    output logic              ld_start,
    input  logic              ld_ready,
    output logic              cp_start,
    input  logic              cp_ready,
    output logic              or_start,
    input  logic              or_ready,
    input  logic              or_done,
    output logic              stall,
    output logic [2:0]        stall_stage
);

    logic [1:0]        state;
    logic [ITER_W-1:0] num_iter;
    logic [ITER_W-1:0] issued;
    logic [ITER_W-1:0] completed;
    logic [ITER_W-1:0] completed_nxt;
    logic [WD_W-1:0]   wd;
    logic              run;
    logic              accept;
    logic              cp_full, cp_nonempty, or_full, or_nonempty;
    logic              ld_hs, cp_hs, or_hs, od_run, progress;
    logic [2:0]        stage_now;

    assign run    = (state == RUN);
    assign accept = (state == IDLE) && cfg_start;

    assign ld_start = run && (issued < num_iter) && !cp_full && !or_full;
    assign cp_start = run && cp_nonempty;
    assign or_start = run && or_nonempty;

    assign ld_hs    = ld_start && ld_ready;
    assign cp_hs    = cp_start && cp_ready;
    assign or_hs    = or_start && or_ready;
    assign od_run   = run && or_done;
    assign progress = ld_hs || cp_hs || or_hs || od_run;

    assign completed_nxt = completed + ITER_W'(od_run);

    assign busy = run;
    assign done = (state == FIN);

    // Which stages are waiting on their ap_ready right now
    always_comb begin
        stage_now     = 3'b000;
        stage_now[LD] = ld_start && !ld_ready;
        stage_now[CP] = cp_start && !cp_ready;
        stage_now[OR] = or_start && !or_ready;
    end

    fc_seq_tok_cnt #(.DEPTH(DEPTH)) u_cp_tok (
        .clock    (clock),
        .reset    (reset),
        .clr      (accept),
        .inc      (ld_hs),
        .dec      (cp_hs),
        .full     (cp_full),
        .nonempty (cp_nonempty)
    );

    fc_seq_tok_cnt #(.DEPTH(DEPTH)) u_or_tok (
        .clock    (clock),
        .reset    (reset),
        .clr      (accept),
        .inc      (ld_hs),
        .dec      (or_hs),
        .full     (or_full),
        .nonempty (or_nonempty)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            num_iter    <= '0;
            issued      <= '0;
            completed   <= '0;
            wd          <= '0;
            stall       <= 1'b0;
            stall_stage <= 3'b000;
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_start) begin
                        num_iter    <= cfg_num_iter;
                        issued      <= '0;
                        completed   <= '0;
                        wd          <= '0;
                        stall       <= 1'b0;
                        stall_stage <= 3'b000;
                        state       <= (cfg_num_iter != '0) ? RUN : FIN;
                    end
                end
                RUN: begin
                    issued    <= issued + ITER_W'(ld_hs);
                    completed <= completed_nxt;
                    if (completed_nxt == num_iter) begin
                        state <= FIN;
                    end
                    // wd parks at the limit so the flag stays asserted without wrapping
                    if (progress) begin
                        wd <= '0;
                    end else if (wd == WD_W'(STALL_CYC - 1)) begin
                        if (!stall) begin
                            stall_stage <= stage_now;
                        end
                        stall <= 1'b1;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
